// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light cluster: mode encoding,
// lamp patterns and default blink timing.
package tail_light_pkg;

  localparam int unsigned LED_W          = 3;
  localparam int unsigned MODE_W         = 2;
  localparam int unsigned BLINK_HALF_DEF = 500;
  localparam int unsigned CNT_W_DEF      = 9;

  typedef enum logic [MODE_W-1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } mode_t;

  localparam logic [LED_W-1:0] LEDS_OFF = 3'b000;
  localparam logic [LED_W-1:0] LEDS_ON  = 3'b111;

endpackage

// File: rtl/tl_blink_timer.sv
// Half-period blink timer: restart loads phase high, then phase toggles
// every BLINK_HALF cycles while run is asserted.
module tl_blink_timer #(
  parameter int unsigned BLINK_HALF = tail_light_pkg::BLINK_HALF_DEF,
  parameter int unsigned CNT_W      = tail_light_pkg::CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic phase
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (run) begin
      if (cnt == CNT_W'(BLINK_HALF - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt   <= '0;
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/tail_light_ctrl.sv
// Tail-light cluster sequencer: synchronizes switches, arbitrates the lamp
// mode, enables the turn sequencers and merges patterns with blink/brake.
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int unsigned BLINK_HALF = BLINK_HALF_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              left_sw,
  input  logic              right_sw,
  input  logic              hazard_sw,
  input  logic              brake,
  input  logic [LED_W-1:0]  left_seq_leds,
  input  logic [LED_W-1:0]  right_seq_leds,
  output logic              left_ena,
  output logic              right_ena,
  output logic [LED_W-1:0]  left_leds,
  output logic [LED_W-1:0]  right_leds,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned SW_W = 4;

  logic [SW_W-1:0] sync1, sync2;
  logic            left_s, right_s, hazard_s, brake_s;
  mode_t           mode_q, mode_next;
  logic            phase;
  logic            blink_run, blink_restart;
  logic [LED_W-1:0] brake_leds;

  // Two-flop synchronizer for all asynchronous switch inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {hazard_sw, brake, right_sw, left_sw};
      sync2 <= sync1;
    end
  end

  assign left_s   = sync2[0];
  assign right_s  = sync2[1];
  assign brake_s  = sync2[2];
  assign hazard_s = sync2[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= IDLE;
    else        mode_q <= mode_next;
  end

  // Turn modes always fall back through IDLE so the sequencers restart
  always_comb begin
    mode_next = mode_q;
    if (hazard_s) begin
      mode_next = HAZARD;
    end else begin
      unique case (mode_q)
        IDLE: begin
          if (left_s && !right_s)      mode_next = LEFT;
          else if (right_s && !left_s) mode_next = RIGHT;
          else                         mode_next = IDLE;
        end
        LEFT:    if (!left_s || right_s) mode_next = IDLE;
        RIGHT:   if (!right_s || left_s) mode_next = IDLE;
        HAZARD:  mode_next = IDLE;
        default: mode_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_ena  <= 1'b0;
      right_ena <= 1'b0;
    end else begin
      left_ena  <= (mode_next == LEFT);
      right_ena <= (mode_next == RIGHT);
    end
  end

  assign blink_run     = (mode_q == HAZARD);
  assign blink_restart = (mode_next == HAZARD) && (mode_q != HAZARD);

  tl_blink_timer #(
    .BLINK_HALF (BLINK_HALF),
    .CNT_W      (CNT_W)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (blink_run),
    .restart (blink_restart),
    .phase   (phase)
  );

  assign brake_leds = brake_s ? LEDS_ON : LEDS_OFF;

  // Lamp merge: hazard blink overrides brake, turn side passes its pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_leds  <= LEDS_OFF;
      right_leds <= LEDS_OFF;
    end else begin
      unique case (mode_q)
        HAZARD: begin
          left_leds  <= {LED_W{phase}};
          right_leds <= {LED_W{phase}};
        end
        LEFT: begin
          left_leds  <= left_seq_leds;
          right_leds <= brake_leds;
        end
        RIGHT: begin
          left_leds  <= brake_leds;
          right_leds <= right_seq_leds;
        end
        default: begin
          left_leds  <= brake_leds;
          right_leds <= brake_leds;
        end
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Scoreboard bench for tail_light_ctrl: a cycle-level reference model built
// from pin history pushes expected outputs; a monitor pops and compares.
module tb_tail_light_ctrl;

  localparam int unsigned BH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       left_sw, right_sw, hazard_sw, brake;
  logic [2:0] left_seq_leds, right_seq_leds;
  logic       left_ena, right_ena;
  logic [2:0] left_leds, right_leds;
  logic [1:0] mode;

  typedef struct packed {
    logic [1:0] mode;
    logic       le;
    logic       re;
    logic [2:0] ll;
    logic [2:0] rl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: mode as 0..3, cycles spent in hazard, pin history {h,b,r,l}
  int         m_mode;
  int         hz_age;
  logic [3:0] p1, p2;

  tail_light_ctrl #(.BLINK_HALF(BH), .CNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .left_sw        (left_sw),
    .right_sw       (right_sw),
    .hazard_sw      (hazard_sw),
    .brake          (brake),
    .left_seq_leds  (left_seq_leds),
    .right_seq_leds (right_seq_leds),
    .left_ena       (left_ena),
    .right_ena      (right_ena),
    .left_leds      (left_leds),
    .right_leds     (right_leds),
    .mode           (mode)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0;
    hz_age = 0;
    p1     = '0;
    p2     = '0;
  endtask

  // Predict the outputs produced by the coming clock edge from the current pins
  task automatic drive_and_push(input logic l, input logic r, input logic h, input logic b);
    logic [3:0] p0;
    logic       ph;
    int         nm;
    exp_t       e;
    left_sw        = l;
    right_sw       = r;
    hazard_sw      = h;
    brake          = b;
    left_seq_leds  = 3'($urandom);
    right_seq_leds = 3'($urandom);
    p0 = {h, b, r, l};
    ph = ((hz_age / BH) % 2) == 0;
    case (m_mode)
      3: begin e.ll = ph ? 3'b111 : 3'b000; e.rl = e.ll; end
      1: begin e.ll = left_seq_leds; e.rl = p2[2] ? 3'b111 : 3'b000; end
      2: begin e.rl = right_seq_leds; e.ll = p2[2] ? 3'b111 : 3'b000; end
      default: begin e.ll = p2[2] ? 3'b111 : 3'b000; e.rl = e.ll; end
    endcase
    if (p2[3]) nm = 3;
    else if (m_mode == 0) nm = (p2[0] ^ p2[1]) ? (p2[0] ? 1 : 2) : 0;
    else if (m_mode == 1) nm = (p2[0] && !p2[1]) ? 1 : 0;
    else if (m_mode == 2) nm = (p2[1] && !p2[0]) ? 2 : 0;
    else nm = 0;
    e.mode = 2'(nm);
    e.le   = (nm == 1);
    e.re   = (nm == 2);
    hz_age = (nm == 3 && m_mode == 3) ? hz_age + 1 : 0;
    m_mode = nm;
    p2     = p1;
    p1     = p0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic l, input logic r, input logic h, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_and_push(l, r, h, b);
    end
  endtask

  task automatic do_reset(input bit check_async);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (check_async) begin
      tests++;
      if ({mode, left_ena, right_ena, left_leds, right_leds} !== 10'b0) begin
        fails++;
        $display("FAIL async_reset got mode=%b ena=%b%b l=%b r=%b, required all zero",
                 mode, left_ena, right_ena, left_leds, right_leds);
      end
    end
    left_sw = 0; right_sw = 0; hazard_sw = 0; brake = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_and_push(0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {mode, left_ena, right_ena, left_leds, right_leds};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got mode=%b ena=%b%b l=%b r=%b, required mode=%b ena=%b%b l=%b r=%b",
                 $time, a.mode, a.le, a.re, a.ll, a.rl, e.mode, e.le, e.re, e.ll, e.rl);
      end
    end
  end

  initial begin
    logic l, r, h, b;
    rst_n = 1'b0;
    left_sw = 0; right_sw = 0; hazard_sw = 0; brake = 0;
    left_seq_leds = '0; right_seq_leds = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_and_push(0, 0, 0, 0);
    step(0, 0, 0, 0, 20);                // idle after reset
    step(1, 0, 0, 0, 10);                // left turn
    step(1, 0, 0, 1, 8);                 // brake during left
    step(1, 0, 0, 0, 6);
    step(0, 1, 0, 0, 10);                // direction switch through idle
    step(0, 0, 0, 0, 5);
    step(1, 0, 0, 1, 5);
    step(1, 0, 1, 1, 20);                // hazard overrides turn and brake
    do_reset(1'b1);                      // async reset mid-hazard
    step(1, 1, 0, 0, 10);                // invalid both-turn request
    step(0, 0, 0, 0, 4);
    l = 0; r = 0; h = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) l = ~l;
      if ($urandom_range(11) == 0) r = ~r;
      if ($urandom_range(29) == 0) h = ~h;
      if ($urandom_range(7) == 0)  b = ~b;
      step(l, r, h, b, 1);
      if (i == 1500) do_reset(1'b1);
    end
    step(0, 0, 0, 0, 3);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tail_light_ctrl.md
Name: tail_light_ctrl

Overview:
Top-level sequencer for the tail-light cluster. Turn, hazard and brake switches are synchronized and arbitrated into one mode. The block drives the enable inputs of the left and right 3-LED turn sequencers. It merges their LED patterns with hazard blink and brake overrides into the final six LED outputs.

Parameters:
BLINK_HALF, 500, clock cycles per hazard half-period (1 Hz blink at 1 kHz clk)
CNT_W, 9, width of the hazard blink counter; must satisfy 2^CNT_W > BLINK_HALF

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
left_sw  in  1  left turn request, asynchronous switch
right_sw  in  1  right turn request, asynchronous switch
hazard_sw  in  1  hazard request, asynchronous switch
brake  in  1  brake pedal, asynchronous
left_seq_leds  in  3  pattern from left turn sequencer
right_seq_leds  in  3  pattern from right turn sequencer
left_ena  out  1  enable to left turn sequencer
right_ena  out  1  enable to right turn sequencer
left_leds  out  3  final left lamp drive
right_leds  out  3  final right lamp drive
mode  out  2  current mode, for debug

Behaviour:
- Reset (rst_n low, async): mode=IDLE; left_ena=right_ena=0; left_leds=right_leds=3'b000; blink counter=0; blink phase=0; synchronizer flops=0.
- Every input switch passes through a 2-flop synchronizer. The arbiter sees the synchronized value 2 cycles after the pin changes.
- Mode encoding: IDLE=2'b00, LEFT=2'b01, RIGHT=2'b10, HAZARD=2'b11. The mode register updates once per clk.
- Arbitration priority (synchronized inputs): hazard > (left XOR right) > idle.
  - left and right both high without hazard is invalid and selects IDLE.
- Transitions:
  - Any mode goes to HAZARD when hazard=1.
  - IDLE goes to LEFT when only left=1, and to RIGHT when only right=1.
  - LEFT goes to IDLE when left drops or right rises; RIGHT behaves symmetrically.
  - A direct LEFT<->RIGHT change is not allowed. The block spends at least 1 cycle in IDLE with both enables low, so the sequencers reset their counters.
  - HAZARD goes to IDLE when hazard drops. It never jumps straight to a turn mode.
- Enables are registered from the next mode: left_ena=1 only in LEFT, right_ena=1 only in RIGHT. Both are 0 in IDLE and HAZARD. Enable latency is 3 clk edges from a pin change.
- Hazard blink timer:
  - Active only in HAZARD; cleared to 0 with phase=1 on HAZARD entry.
  - Counts 0..BLINK_HALF-1, then wraps to 0 and toggles phase.
  - The lamps start ON in the first cycle of HAZARD.
- LED merge, registered with 1 cycle latency from mode/seq inputs:
  - HAZARD: both sides = {3{phase}}; brake is ignored.
  - LEFT: left_leds=left_seq_leds; right_leds = brake ? 3'b111 : 3'b000.
  - RIGHT: mirror of LEFT.
  - IDLE: both sides = brake ? 3'b111 : 3'b000.
- Sequencer patterns are passed through unmodified. The block does not inspect them.
- Reset asserted mid-sequence forces all outputs low immediately (async). After release, the block restarts from IDLE.

Decomposition:
- Shared package tail_light_pkg holds:
  - Mode encodings IDLE/LEFT/RIGHT/HAZARD.
  - LED constants LEDS_OFF=3'b000 and LEDS_ON=3'b111.
  - Default BLINK_HALF.
- One natural sub-module, tl_blink_timer (inputs: clk, rst_n, run, restart; output: phase). It is reusable by the turn sequencers' timing.
- The synchronizers are inlined.

Test Plan:
- Reset/idle: hold rst_n=0, then release with all switches 0 -> outputs stay 0, mode=00 for 20 cycles.
- Left turn: raise left_sw at cycle 0 -> left_ena=1 after the 3rd edge, mode=01. left_seq_leds=3'b110 appears on left_leds 1 cycle later; right_leds=000.
- Brake during left turn: brake=1 -> right_leds=111 after 3 edges; left_leds keeps tracking left_seq_leds; release brake -> right_leds=000.
- Direction switch: with left active, drop left_sw and raise right_sw on the same edge -> at least 1 cycle with left_ena=right_ena=0 and mode=00, then right_ena=1 and mode=10.
- Hazard override (BLINK_HALF=4): assert hazard_sw with left_sw and brake high -> enables drop to 0. Both sides read 111 for 4 cycles, then 000 for 4 cycles, repeating; brake has no effect.
- Invalid and reset: left_sw=right_sw=1 -> mode stays 00. Assert rst_n=0 mid-hazard -> outputs are 000 the same cycle without a clock edge.
